// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the round-robin memory arbiter.
// Holds the FSM state encoding, default widths and the locked-burst limit.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_RD_LAT  = 1;

  // Maximum number of back-to-back transactions under one locked grant.
  localparam int LOCK_LIMIT  = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational round-robin picker: searches upward from last_winner+1 (wrapping)
// and returns the first active requester as a one-hot grant plus its index.
module mem_arb_rr
  import mem_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_winner,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    found     = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_winner) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters single transactions on one memory port.
// Define MEM_ARB_LOCK_EN to add the lock input for bounded back-to-back locked bursts.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RD_LAT  = DEF_RD_LAT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]    lock,
`endif
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic [DATA_W-1:0]     rdata,
  output logic                  mem_ce,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int         IDX_W     = idx_width(NUM_REQ);
  localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          wait_cnt_q, wait_cnt_d;
`ifdef MEM_ARB_LOCK_EN
  logic [2:0]          burst_q, burst_d;
`endif

  logic [NUM_REQ-1:0]  rr_grant;
  logic [IDX_W-1:0]    rr_idx;
  logic [IDX_W-1:0]    cap_idx;
  logic                cap_we;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_wdata;

  mem_arb_rr #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req         (req),
    .last_winner (last_q),
    .grant       (rr_grant),
    .grant_idx   (rr_idx)
  );

  // Capture source: the new winner from IDLE, or the current owner on a locked re-capture.
  always_comb begin
    cap_idx   = (state_q == IDLE) ? rr_idx : idx_q;
    cap_we    = req_we[cap_idx];
    cap_addr  = req_addr[cap_idx*ADDR_W +: ADDR_W];
    cap_wdata = req_wdata[cap_idx*DATA_W +: DATA_W];
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    idx_d      = idx_q;
    last_d     = last_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    wait_cnt_d = wait_cnt_q;
`ifdef MEM_ARB_LOCK_EN
    burst_d    = burst_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = rr_grant;
          idx_d   = rr_idx;
          we_d    = cap_we;
          addr_d  = cap_addr;
          wdata_d = cap_wdata;
          state_d = ACCESS;
`ifdef MEM_ARB_LOCK_EN
          burst_d = 3'd1;
`endif
        end
      end
      ACCESS: begin
        wait_cnt_d = '0;
        state_d    = we_q ? DONE : WAIT;
      end
      WAIT: begin
        if (wait_cnt_q == LAST_WAIT) begin
          rdata_d = mem_rdata;
          state_d = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      DONE: begin
        last_d  = idx_q;
        gnt_d   = '0;
        state_d = IDLE;
`ifdef MEM_ARB_LOCK_EN
        // Locked owner keeps the grant, up to LOCK_LIMIT transactions in a row.
        if (lock[idx_q] && req[idx_q] && (burst_q < 3'(LOCK_LIMIT))) begin
          gnt_d   = gnt_q;
          we_d    = cap_we;
          addr_d  = cap_addr;
          wdata_d = cap_wdata;
          burst_d = burst_q + 3'd1;
          state_d = ACCESS;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      idx_q      <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      wait_cnt_q <= '0;
`ifdef MEM_ARB_LOCK_EN
      burst_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      wait_cnt_q <= wait_cnt_d;
`ifdef MEM_ARB_LOCK_EN
      burst_q    <= burst_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign done      = (state_q == DONE) ? gnt_q : '0;
  assign rdata     = rdata_q;
  assign mem_ce    = (state_q == ACCESS);
  assign mem_we    = mem_ce & we_q;
  assign mem_addr  = mem_ce ? addr_q  : '0;
  assign mem_wdata = mem_ce ? wdata_q : '0;

endmodule
